// File: rtl/om_port_arbiter.sv
// rtl/om_port_arbiter.sv - object-memory port arbiter for three masters
//
// Shares the single synchronous OM RAM port between master 0 (new-game
// coordinator), master 1 (entities mover) and master 2 (game logic).
// A granted master keeps the port for as long as it holds req. A hold limit
// hands the port over when another master is waiting.
//
// Build option: define OM_ARB_ROUND_ROBIN_EN for rotating priority, where the
// search starts after the last winner. When it is not defined, priority is
// fixed at 0 > 1 > 2.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   req, we               per-master request (held = keep port), write enable
//   addr, wdata           packed per-master address/data, master i at slice i
//   gnt                   registered one-hot grant
//   rvalid, rdata         per-master read strobe; shared read data
//   mem_addr, mem_wdata,  OM RAM port; mem_rdata valid one cycle after mem_addr
//   mem_wren, mem_rdata
//   addr_err              pulses one cycle after an out-of-range granted beat
//   busy                  any grant bit high
module om_port_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 11,
  parameter int DEPTH    = 124,
  parameter int MAX_HOLD = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wren,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                addr_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWNED   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       skip_mask;  // master preempted by the hold limit
  logic             rd_oor;     // last read beat was out of range
`ifdef OM_ARB_ROUND_ROBIN_EN
  logic [1:0]       rr_ptr;
`endif

  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              own_we;
  logic              beat;
  logic              in_range;
  logic              others_req;
  logic [2:0]        cand;
  logic [1:0]        start;
  logic [1:0]        win;

  // The owner's inputs are routed to the RAM. gnt is zero outside OWNED, so
  // the RAM port then sits at all zeros.
  always_comb begin
    own_addr  = '0;
    own_wdata = '0;
    own_we    = 1'b0;
    if (gnt[0]) begin
      own_addr  = addr[0 +: ADDR_W];
      own_wdata = wdata[0 +: DATA_W];
      own_we    = we[0];
    end else if (gnt[1]) begin
      own_addr  = addr[ADDR_W +: ADDR_W];
      own_wdata = wdata[DATA_W +: DATA_W];
      own_we    = we[1];
    end else if (gnt[2]) begin
      own_addr  = addr[2*ADDR_W +: ADDR_W];
      own_wdata = wdata[2*DATA_W +: DATA_W];
      own_we    = we[2];
    end
  end

  assign beat       = |(req & gnt);
  assign in_range   = {1'b0, own_addr} < DEPTH_LIM;
  assign others_req = |(req & ~gnt);

  assign mem_addr  = own_addr;
  assign mem_wdata = own_wdata;
  assign mem_wren  = beat & own_we & in_range;
  assign busy      = |gnt;
  // The RAM output is valid in the cycle rvalid is high. Out-of-range reads
  // are forced to zero.
  assign rdata     = (|rvalid && !rd_oor) ? mem_rdata : '0;

  // A master that was just preempted sits out one arbitration if anyone else
  // is asking. Otherwise fixed priority would hand the port straight back.
  assign cand = (|(req & ~skip_mask)) ? (req & ~skip_mask) : req;

`ifdef OM_ARB_ROUND_ROBIN_EN
  assign start = rr_ptr;
`else
  assign start = 2'd0;
`endif

  // The search runs backwards so the first candidate in priority order is
  // written last and wins.
  always_comb begin
    logic [2:0] pos;
    win = 2'd0;
    pos = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      pos = {1'b0, start} + 3'(k);
      if (pos >= 3'd3) pos = pos - 3'd3;
      if (cand[pos[1:0]]) win = pos[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      rvalid    <= '0;
      addr_err  <= 1'b0;
      hold_cnt  <= '0;
      skip_mask <= '0;
      rd_oor    <= 1'b0;
`ifdef OM_ARB_ROUND_ROBIN_EN
      rr_ptr    <= 2'd0;
`endif
    end else begin
      rvalid   <= '0;
      addr_err <= 1'b0;
      // These strobes come from the beat itself. A read on the last granted
      // cycle is still answered after the grant drops.
      if (beat) begin
        addr_err <= !in_range;
        if (!own_we) begin
          rvalid <= gnt;
          rd_oor <= !in_range;
        end
      end

      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt       <= 3'b001 << win;
            hold_cnt  <= '0;
            skip_mask <= '0;
            state     <= ST_OWNED;
`ifdef OM_ARB_ROUND_ROBIN_EN
            rr_ptr    <= (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
          end
        end
        ST_OWNED: begin
          if (!beat) begin
            gnt   <= '0;
            state <= ST_RELEASE;
          end else if (hold_cnt == HOLD_LAST && others_req) begin
            skip_mask <= gnt;
            gnt       <= '0;
            state     <= ST_RELEASE;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default: begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_om_port_arbiter.sv
// tb/tb_om_port_arbiter.sv - randomized scoreboard bench for om_port_arbiter
module tb_om_port_arbiter;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 11;
  localparam int DEPTH    = 124;
  localparam int MAX_HOLD = 64;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b1;
  logic [2:0]          req   = '0;
  logic [2:0]          we    = '0;
  logic [3*ADDR_W-1:0] addr  = '0;
  logic [3*DATA_W-1:0] wdata = '0;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_wren;
  logic [DATA_W-1:0]   mem_rdata;
  logic                addr_err;
  logic                busy;

  always #5 clk = ~clk;

  om_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
    .addr_err(addr_err), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] seed_word(input int i);
    return DATA_W'((i * 37 + 5) % 2048);
  endfunction

  // OM RAM: synchronous read, contents preloaded (including 124..127)
  logic [DATA_W-1:0] ram [128];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 128; i++) ram[i] <= seed_word(i);
      ram_loaded <= 1'b1;
    end else begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct { int cyc; int m; int d; } exp_t;
  exp_t q_gnt[$], q_rel[$], q_rd[$], q_err[$], q_wr[$];

  function automatic exp_t mk(input int c, input int m, input int d);
    exp_t e;
    e.cyc = c; e.m = m; e.d = d;
    return e;
  endfunction

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic missed(input string name, input int exp_cyc);
    tests++;
    fails++;
    $display("FAIL %s: expected at cycle %0d, not seen by cycle %0d", name, exp_cyc, cyc);
  endtask

  task automatic unexpected(input string name, input int act);
    tests++;
    fails++;
    $display("FAIL %s at cycle %0d: got event 0x%0h, expected none", name, cyc, act);
  endtask

  // Reference model: the owner, its hold time and the enforced gap, kept as
  // plain integers. It is evaluated mid-cycle on the inputs applied that cycle.
  int m_owner = -1;
  int m_held  = 0;
  int m_block = 0;
  int m_skip  = -1;
  int m_ptr   = 0;
  logic [DATA_W-1:0] ref_mem [128];
  bit ref_loaded = 1'b0;

  always @(negedge clk) begin
    int a, d, win;
    logic [2:0] cand;
    if (!ref_loaded) begin
      for (int i = 0; i < 128; i++) ref_mem[i] = seed_word(i);
      ref_loaded = 1'b1;
    end
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_block = 0; m_skip = -1; m_ptr = 0;
      q_gnt.delete(); q_rel.delete(); q_rd.delete(); q_err.delete(); q_wr.delete();
    end else if (m_owner >= 0) begin
      a = int'(addr[m_owner*ADDR_W +: ADDR_W]);
      d = int'(wdata[m_owner*DATA_W +: DATA_W]);
      if (req[m_owner]) begin
        if (we[m_owner]) begin
          if (a < DEPTH) begin
            q_wr.push_back(mk(cyc, a, d));
            ref_mem[a] = DATA_W'(d);
          end
        end else begin
          q_rd.push_back(mk(cyc + 1, m_owner, (a < DEPTH) ? int'(ref_mem[a]) : 0));
        end
        if (a >= DEPTH) q_err.push_back(mk(cyc + 1, m_owner, 0));
        m_held++;
        if (m_held >= MAX_HOLD && (req & ~(3'b001 << m_owner)) != 3'b000) begin
          q_rel.push_back(mk(cyc + 1, m_owner, 0));
          m_skip = m_owner; m_owner = -1; m_block = 1;
        end
      end else begin
        q_rel.push_back(mk(cyc + 1, m_owner, 0));
        m_owner = -1; m_block = 1;
      end
    end else if (m_block > 0) begin
      m_block--;
    end else if (req != 3'b000) begin
      cand = req;
      if (m_skip >= 0 && (req & ~(3'b001 << m_skip)) != 3'b000) cand[m_skip] = 1'b0;
      win = -1;
      for (int k = 0; k < 3; k++)
        if (win < 0 && cand[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
      q_gnt.push_back(mk(cyc + 1, win, 0));
      m_owner = win; m_held = 0; m_skip = -1;
`ifdef OM_ARB_ROUND_ROBIN_EN
      m_ptr = (win + 1) % 3;
`endif
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event
  logic [2:0] prev_gnt = '0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("rst_gnt", int'(gnt), 0);
        check("rst_mem_wren", int'(mem_wren), 0);
        check("rst_rvalid", int'(rvalid), 0);
        check("rst_rdata", int'(rdata), 0);
        check("rst_addr_err", int'(addr_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        prev_gnt = '0;
      end else begin
        check("busy", int'(busy), int'(|gnt));
        check("gnt_onehot", int'($countones(gnt) <= 1), 1);
        if (mem_wren) check("wren_needs_gnt", int'(|gnt), 1);

        while (q_gnt.size() > 0 && q_gnt[0].cyc < cyc) begin missed("grant", q_gnt[0].cyc); q_gnt.delete(0); end
        while (q_rel.size() > 0 && q_rel[0].cyc < cyc) begin missed("release", q_rel[0].cyc); q_rel.delete(0); end
        while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin missed("rvalid", q_rd[0].cyc); q_rd.delete(0); end
        while (q_err.size() > 0 && q_err[0].cyc < cyc) begin missed("addr_err", q_err[0].cyc); q_err.delete(0); end
        while (q_wr.size() > 0 && q_wr[0].cyc < cyc) begin missed("mem_wren", q_wr[0].cyc); q_wr.delete(0); end

        if (gnt != 3'b000 && prev_gnt == 3'b000) begin
          if (q_gnt.size() > 0) begin
            check("grant_cycle", cyc, q_gnt[0].cyc);
            check("grant_vector", int'(gnt), 1 << q_gnt[0].m);
            q_gnt.delete(0);
          end else unexpected("grant", int'(gnt));
        end
        if (gnt != 3'b000 && prev_gnt != 3'b000) check("grant_stable", int'(gnt), int'(prev_gnt));
        if (gnt == 3'b000 && prev_gnt != 3'b000) begin
          if (q_rel.size() > 0) begin
            check("release_cycle", cyc, q_rel[0].cyc);
            check("release_owner", int'(prev_gnt), 1 << q_rel[0].m);
            q_rel.delete(0);
          end else unexpected("release", int'(prev_gnt));
        end
        if (rvalid != 3'b000) begin
          if (q_rd.size() > 0) begin
            check("read_cycle", cyc, q_rd[0].cyc);
            check("read_rvalid", int'(rvalid), 1 << q_rd[0].m);
            check("read_rdata", int'(rdata), q_rd[0].d);
            q_rd.delete(0);
          end else unexpected("rvalid", int'(rvalid));
        end
        if (addr_err) begin
          if (q_err.size() > 0) begin
            check("addr_err_cycle", cyc, q_err[0].cyc);
            q_err.delete(0);
          end else unexpected("addr_err", 1);
        end
        if (mem_wren) begin
          if (q_wr.size() > 0) begin
            check("write_cycle", cyc, q_wr[0].cyc);
            check("write_addr", int'(mem_addr), q_wr[0].m);
            check("write_data", int'(mem_wdata), q_wr[0].d);
            q_wr.delete(0);
          end else unexpected("mem_wren", int'(mem_addr));
        end
        prev_gnt = gnt;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input bit w, input int a, input int d);
    we[i] = w;
    addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wdata[i*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic random_phase(input int cycles, input int drop_n);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, drop_n - 1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
        set_m(i, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 127)) : int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(0, 2047)));
      end
      step(1);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    // master 2 writes 0x300 to 43, then reads it back
    req = 3'b100; set_m(2, 1'b1, 43, 'h300);
    step(2);
    set_m(2, 1'b0, 43, 0);
    step(1);
    req = 3'b000;
    step(4);

    // simultaneous requests; master 0 drops after a few beats
    req = 3'b111;
    for (int i = 0; i < 3; i++) set_m(i, 1'b0, 10 + i, 0);
    step(4);
    req[0] = 1'b0;
    step(8);
    req = 3'b000;
    step(4);

    // master 1 holds with writes; master 2 waits -> hold-limit handover
    req = 3'b010;
    for (int k = 0; k < 80; k++) begin
      set_m(1, 1'b1, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2047)));
      if (k == 5) begin req[2] = 1'b1; set_m(2, 1'b0, 20, 0); end
      step(1);
    end
    req = 3'b000;
    step(4);

    // out-of-range write and reads, then a metadata read
    req = 3'b100; set_m(2, 1'b1, 124, 5);
    step(2);
    set_m(2, 1'b0, 127, 0);
    step(1);
    set_m(2, 1'b0, 100, 0);
    step(1);
    req = 3'b000;
    step(4);

    // reset in the middle of a write burst
    req = 3'b010; set_m(1, 1'b1, 30, 'h123);
    step(4);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(4);
    req = 3'b000;
    step(4);

    random_phase(3000, 10);
    random_phase(1500, 100);

    req = 3'b000;
    step(10);
    check("pending_grants", q_gnt.size(), 0);
    check("pending_releases", q_rel.size(), 0);
    check("pending_reads", q_rd.size(), 0);
    check("pending_addr_errs", q_err.size(), 0);
    check("pending_writes", q_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
